wav_recorder: RTL
=================

# wav_recorder

Audio sample capture engine: the write-side counterpart of the sound block's sample player. On a start pulse it samples an 8-bit unsigned audio stream at a fixed prescaled rate and writes consecutive samples into a dual-port sample RAM from address 0 upward. The player on the other RAM port can then replay the buffer. A busy flag drives a LED; a done pulse and a sample count are reported on completion.

## Interface

- `ADDR_W`, 14: RAM address width; buffer holds 2^ADDR_W samples.
- `DIV`, 2178: clock cycles per sample period; 8 kHz-class rate at `clk_sys`.
- `THRESH`, 8'd16: trigger threshold around midscale 8'h80. Used only with the macro in Configuration.

Ports:

- `CLK` in 1: system clock. One clock only.
- `reset` in 1: asynchronous, active-high.
- `switch_rec` in 1: one-cycle start pulse, from debounce `o_onup`.
- `switch_stop` in 1: one-cycle stop pulse.
- `audio_in` in 8: unsigned sample, 8'h80 = silence.
- `ram_a` out ADDR_W: write address.
- `ram_d` out 8: write data.
- `ram_we` out 1: write strobe, one cycle per sample.
- `rec` out 1: high while ARM or RECORD.
- `done` out 1: one-cycle completion pulse.
- `length` out ADDR_W+1: samples written in the current or last capture.

## Operation

States:

- **IDLE**
  - `switch_rec` without `switch_stop` → RECORD, or ARM when the trigger is compiled in.
  - `switch_rec` and `switch_stop` in the same cycle: stop wins; stay in IDLE.
- **ARM** (macro only)
  - Condition `|audio_in − 8'h80| ≥ THRESH`, computed 9-bit, no wrap → RECORD.
  - `switch_stop` → DONE.
- **RECORD**
  - Prescaler counts 0..DIV−1, then wraps. A tick is the cycle with prescaler == DIV−1.
  - On a tick: `ram_a` ← addr, `ram_d` ← `audio_in`, `ram_we` ← 1, addr ← addr+1, `length` ← `length`+1.
  - After the write to address 2^ADDR_W−1 → DONE, with `length` = 2^ADDR_W. The address never wraps and nothing is overwritten.
  - `switch_stop` → DONE. If stop coincides with a tick, that sample is still written and counted.
  - `switch_rec` while in ARM or RECORD is ignored. There is no restart.
- **DONE**
  - `done` = 1 for exactly one cycle, then IDLE.
  - `length` holds its value until the next accepted start.

On entry to RECORD or ARM, addr, prescaler and `length` clear to 0.

Reset, asynchronous, at any time including mid-capture:

- State → IDLE.
- Prescaler, addr, `ram_a`, `ram_d`, `length` → 0.
- `ram_we`, `rec`, `done` → 0.
- No partial write is issued, and no `done` pulse is emitted for an aborted capture.

## Timing

- A start pulse in cycle 0 puts the block in RECORD from cycle 1 with prescaler = 0. `rec` = 1 from cycle 1.
- The first tick is in cycle DIV. `ram_we` is high in cycle DIV+1 with `ram_a` = 0.
- Subsequent writes follow every DIV cycles.
- `ram_a`/`ram_d` are registered and stable while `ram_we` is high. They hold their last value otherwise.
- `length` updates in the same cycle `ram_we` rises.
- Timing from the final write:
  - The final-write tick moves the state to DONE in the next cycle, which is the same cycle `ram_we` is high.
  - `done` is high in that cycle.
  - `rec` falls in that cycle.
  - IDLE follows one cycle later.
- A stop pulse in cycle N gives DONE in N+1: `done` = 1 and `rec` = 0 in N+1.
- In ARM, a trigger condition true in cycle N gives RECORD in N+1 with prescaler = 0.
- Throughput: one write per DIV cycles, with DIV ≥ 2.

## Configuration

- `WAV_RECORDER_TRIGGER_EN` defined:
  - Start enters ARM and waits for the threshold crossing.
  - `rec` is high during ARM.
  - A stop in ARM gives `done` with `length` = 0.
- Not defined:
  - ARM, the threshold comparator and `THRESH` are not used.
  - Start enters RECORD directly.

## Test plan

Parameters for the bench: ADDR_W=4, DIV=4, no macro unless stated.

1. **Full capture.** Pulse `switch_rec` in cycle 0 with `audio_in` ramping 0x10, 0x11, …
   - Exactly 16 `ram_we` pulses, addresses 0..15, first at cycle 5, then every 4 cycles.
   - `done` once; `length` = 16; `rec` low afterward.
2. **Early stop.** Pulse `switch_stop` after the 3rd write.
   - No further writes; `done` next cycle; `length` = 3.
3. **Stop on tick.** Stop in the same cycle as the 5th tick.
   - The 5th write still occurs; `length` = 5.
4. **Simultaneous pulses and re-start.**
   - `switch_rec` + `switch_stop` together in IDLE → no `rec`, no writes.
   - `switch_rec` during RECORD → address sequence unaffected.
5. **Reset mid-capture.** Assert `reset` after 7 writes.
   - All outputs 0 immediately; no `done`.
   - A new start writes from address 0 with `length` restarting at 1.
6. **Trigger (macro defined, THRESH=16).**
   - `audio_in` = 0x85 for 20 cycles → `rec` = 1 but no writes.
   - Then 0x90 → RECORD next cycle; first write after 4 further cycles.

Source files
------------

// File: rtl/wav_recorder_if.sv
// wav_recorder_if
//   Bundles the control, audio and sample-RAM write signals of the
//   wav_recorder capture engine so they travel as a single port.
//
//   Parameter:
//     ADDR_W      RAM address width; must match the recorder instance.
//
//   Signals:
//     switch_rec  one-cycle start pulse
//     switch_stop one-cycle stop pulse
//     audio_in    8-bit unsigned sample, 8'h80 = silence
//     ram_a       RAM write address
//     ram_d       RAM write data
//     ram_we      RAM write strobe, one cycle per sample
//     rec         capture in progress (LED)
//     done        one-cycle completion pulse
//     length      samples written in the current or last capture
//
//   Modports:
//     master      stimulus / control side (drives pulses and audio)
//     slave       the recorder itself
interface wav_recorder_if #(
  parameter int ADDR_W = 14
);
  logic              switch_rec;
  logic              switch_stop;
  logic [7:0]        audio_in;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_d;
  logic              ram_we;
  logic              rec;
  logic              done;
  logic [ADDR_W:0]   length;

  modport master (
    output switch_rec, switch_stop, audio_in,
    input  ram_a, ram_d, ram_we, rec, done, length
  );

  modport slave (
    input  switch_rec, switch_stop, audio_in,
    output ram_a, ram_d, ram_we, rec, done, length
  );
endinterface

// File: rtl/wav_recorder.sv
// wav_recorder
//   Audio sample capture engine. A start pulse begins a capture that
//   samples audio_in once every DIV clocks and writes the samples into a
//   dual-port sample RAM from address 0 upward. Capture ends when the
//   buffer is full (2^ADDR_W samples) or on a stop pulse; a one-cycle
//   done pulse is emitted and length reports the number of samples.
//
//   Optional feature (compile-time macro WAV_RECORDER_TRIGGER_EN):
//     when defined, a start first enters an ARM state and recording only
//     begins once |audio_in - 8'h80| >= THRESH. When undefined the
//     trigger logic and the THRESH parameter do not exist.
//
//   Parameters:
//     ADDR_W   RAM address width
//     DIV      clock cycles per sample period (>= 2)
//     THRESH   trigger threshold around midscale (macro builds only)
//
//   Ports:
//     CLK      system clock
//     reset    asynchronous, active-high reset
//     bus      wav_recorder_if slave modport (pulses, audio, RAM write
//              port, rec/done/length status)
module wav_recorder #(
  parameter int ADDR_W = 14,
  parameter int DIV    = 2178
`ifdef WAV_RECORDER_TRIGGER_EN
  , parameter logic [7:0] THRESH = 8'd16
`endif
) (
  input logic           CLK,
  input logic           reset,
  wav_recorder_if.slave bus
);

  localparam int                PS_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(DIV - 1);
  localparam logic [PS_W-1:0]   PS_ONE    = PS_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RECORD,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [PS_W-1:0]   r_prescale;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ramA;
  logic [7:0]        r_ramD;
  logic              r_ramWe;
  logic [ADDR_W:0]   r_length;
  logic              w_tick;
  logic              w_clear;
  logic              w_write;

`ifdef WAV_RECORDER_TRIGGER_EN
  logic [8:0] w_dist;
  logic       w_trigger;

  // Distance from midscale is formed in 9 bits on the larger-minus-smaller
  // side so it never wraps.
  assign w_dist    = (bus.audio_in >= 8'h80) ? ({1'b0, bus.audio_in} - 9'h080)
                                             : (9'h080 - {1'b0, bus.audio_in});
  assign w_trigger = (w_dist >= {1'b0, THRESH});
`endif

  assign w_tick = (r_state == RECORD) && (r_prescale == PS_LAST);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Stop is checked last in RECORD so it overrides the buffer-full path,
  // while a tick in the same cycle still writes its sample.
  always_comb begin
    w_stateNext = r_state;
    w_clear     = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.switch_rec && !bus.switch_stop) begin
          w_clear = 1'b1;
`ifdef WAV_RECORDER_TRIGGER_EN
          w_stateNext = ARM;
`else
          w_stateNext = RECORD;
`endif
        end
      end
`ifdef WAV_RECORDER_TRIGGER_EN
      ARM: begin
        if (bus.switch_stop) begin
          w_stateNext = DONE;
        end else if (w_trigger) begin
          w_clear     = 1'b1;
          w_stateNext = RECORD;
        end
      end
`endif
      RECORD: begin
        if (w_tick) begin
          w_write = 1'b1;
          if (r_addr == ADDR_LAST) begin
            w_stateNext = DONE;
          end
        end
        if (bus.switch_stop) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // The write port is registered: a tick loads address/data and raises the
  // strobe for exactly the following cycle. Address and data hold between
  // writes. The address register may roll over after the last write, but
  // the FSM has already left RECORD so it is never used.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_prescale <= '0;
      r_addr     <= '0;
      r_ramA     <= '0;
      r_ramD     <= '0;
      r_ramWe    <= 1'b0;
      r_length   <= '0;
    end else begin
      r_ramWe <= w_write;
      if (w_clear) begin
        r_prescale <= '0;
        r_addr     <= '0;
        r_length   <= '0;
      end else begin
        if (r_state == RECORD) begin
          r_prescale <= w_tick ? '0 : (r_prescale + PS_ONE);
        end
        if (w_write) begin
          r_ramA   <= r_addr;
          r_ramD   <= bus.audio_in;
          r_addr   <= r_addr + ADDR_ONE;
          r_length <= r_length + LEN_ONE;
        end
      end
    end
  end

  assign bus.ram_a  = r_ramA;
  assign bus.ram_d  = r_ramD;
  assign bus.ram_we = r_ramWe;
  assign bus.length = r_length;
  assign bus.rec    = (r_state == RECORD) || (r_state == ARM);
  assign bus.done   = (r_state == DONE);

endmodule
